pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and fetch-sequencing stage of the MIPS single-cycle core, directly upstream of `instruction_memory`. It holds the PC and drives it as the fetch address. It computes the next PC from the sequential, branch (`beq`) and jump (`j`) paths, and forwards the fetched word to decode. It also detects normal program end and illegal control-flow targets, and counts fetched instructions for bench visibility.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_WORDS`, 64, instruction memory depth in words. Legal PCs are `0 .. IMEM_WORDS*4-4`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hold the PC this cycle.
- `branch_taken` input 1: resolved `beq` condition (branch AND zero).
- `branch_offset` input 32: sign-extended immediate, in words.
- `jump` input 1: current instruction is `j`.
- `jump_index` input 26: instr[25:0].
- `instruction` input 32: word returned by `instruction_memory`.
- `pc` output 32: current PC; drives the `instruction_memory` address.
- `pc_plus4` output 32: `pc + 4`.
- `instr_out` output 32: `instruction` passed through to decode.
- `halted` output 1: sticky; the sequential path ran off the end of memory.
- `fault` output 1: sticky; a branch or jump target is out of range or misaligned.
- `fetch_count` output 32: number of PC advances since reset.

## Operation
- State: `pc_q`, `halted_q`, `fault_q`, `count_q`.
- Reset values: `pc=RESET_PC`, `halted=0`, `fault=0`, `fetch_count=0`.
- Modes:
  - RUN: `halted=0` and `fault=0`.
  - HALT: `halted=1`.
  - FAULT: `fault=1`.
- HALT and FAULT are absorbing; only `reset` leaves them.
- Candidate next PC, in priority order:
  1. `jump`: `{pc_plus4[31:28], jump_index, 2'b00}`.
  2. `branch_taken`: `pc_plus4 + (branch_offset << 2)`, computed modulo 2^32.
  3. Otherwise: `pc_plus4`.
- Per-edge update priority:
  1. `reset`.
  2. HALT or FAULT: hold all state.
  3. `stall`: hold all state; `jump` and `branch_taken` are ignored, so the requester must re-assert them.
  4. Range check on the candidate:
     - Sequential candidate `>= IMEM_WORDS*4`: set `halted`, hold `pc`.
     - Jump or branch candidate `>= IMEM_WORDS*4`, or with bits[1:0] != 0: set `fault`, hold `pc`.
     - Otherwise: `pc <= candidate` and `fetch_count += 1`.
- `jump` and `branch_taken` both high: jump wins. This is not a fault.
- `fetch_count` wraps modulo 2^32. It does not increment on stall, halt, fault or reset cycles.
- `instr_out` is combinational from `instruction`; no buffering.

## Timing
- The PC is registered. `pc` and `pc_plus4` change only after a rising edge.
- Instruction memory is combinational, so `instr_out` is valid in the same cycle as `pc`.
- Control inputs are sampled at the rising edge. A redirect appears on `pc` one cycle after `jump` or `branch_taken` is sampled. There are no delay slots.
- `halted` and `fault` assert at the same edge that would otherwise have moved the PC, and `pc` shows the last legal address.
- `reset` asserted mid-run restores all reset values at the next edge, regardless of `stall` or control inputs.

## Structure
- Shared package `mips_pkg` holds: `WORD_BYTES=4`, `IMEM_WORDS`, `RESET_PC`, the opcode constants for `beq`/`j`, and the typedef `word_t` (32-bit).
- One combinational sub-module, `pc_next_logic`:
  - Inputs: `pc`, `branch_taken`, `branch_offset`, `jump`, `jump_index`.
  - Outputs: `pc_plus4`, candidate PC, and the `seq_oob` / `ctl_bad` range flags.
- Registers and sticky state stay in `pc_fetch_unit`.

## Test plan
- Reset, then 3 free-running cycles: `pc` shows 0x00, 0x04, 0x08, 0x0C; after them `fetch_count=3`; `halted=0` and `fault=0`.
- At `pc=0x18`, pulse `branch_taken` with `branch_offset=8`: next `pc=0x3C`.
- At `pc=0x18`, pulse `branch_offset=-7` (0xFFFF_FFF9): next `pc=0x00`.
- At `pc=0x3C`, assert `jump` with `jump_index=3` and `branch_taken=1`: next `pc=0x0C` (jump wins).
- Assert `stall` together with `jump` at `pc=0x10`: `pc` stays 0x10 and `fetch_count` is unchanged. Release `stall` with `jump` still high: the jump is taken.
- Branch with `branch_offset=100` at `pc=0x08`: `fault=1`, `pc` stays 0x08, and later inputs are ignored.
- Run sequentially to `pc=0xFC`: on the next edge `halted=1`, `pc` stays 0xFC and `fetch_count=63`.
- Assert `reset`: `pc=0`, `halted=0`, `fault=0` and `fetch_count=0` at the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS single-cycle core.
// Holds the default memory geometry and reset PC used by the fetch stage.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned WORD_BYTES = 32'd4;
    localparam int unsigned IMEM_WORDS = 32'd64;
    localparam word_t       RESET_PC   = 32'h0000_0000;

    localparam logic [5:0]  OP_BEQ     = 6'b000100;
    localparam logic [5:0]  OP_J       = 6'b000010;

    // A fetch address is legal only on a word boundary.
    function automatic logic is_word_aligned(input word_t addr);
        is_word_aligned = (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the fetch stage.
// Produces pc+4, the prioritised candidate PC, and its range flags.
module pc_next_logic
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS
) (
    input  word_t       pc,
    input  logic        branch_taken,
    input  word_t       branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output word_t       pc_plus4,
    output word_t       candidate,
    output logic        seq_oob,
    output logic        ctl_bad
);

    localparam word_t PC_LIMIT = word_t'(IMEM_WORDS * WORD_BYTES);

    word_t branch_target_s;
    word_t jump_target_s;
    logic  is_ctl_s;

    // Jump beats branch beats sequential; the flags classify the chosen path.
    always_comb begin
        pc_plus4        = pc + 32'd4;
        branch_target_s = pc_plus4 + (branch_offset << 2);
        jump_target_s   = {pc_plus4[31:28], jump_index, 2'b00};
        candidate       = pc_plus4;
        is_ctl_s        = 1'b0;
        if (jump) begin
            candidate = jump_target_s;
            is_ctl_s  = 1'b1;
        end else if (branch_taken) begin
            candidate = branch_target_s;
            is_ctl_s  = 1'b1;
        end else begin
            candidate = pc_plus4;
            is_ctl_s  = 1'b0;
        end
        seq_oob = !is_ctl_s && (candidate >= PC_LIMIT);
        ctl_bad = is_ctl_s && ((candidate >= PC_LIMIT) || !is_word_aligned(candidate));
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencing: holds the PC, applies redirects,
// and latches sticky halt/fault status plus a fetch counter.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter word_t       RESET_PC   = mips_pkg::RESET_PC,
    parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_out,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    word_t pc_r;
    logic  halted_r;
    logic  fault_r;
    word_t count_r;

    word_t pc_plus4_s;
    word_t candidate_s;
    logic  seq_oob_s;
    logic  ctl_bad_s;

    pc_next_logic #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_next (
        .pc            (pc_r),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc_plus4      (pc_plus4_s),
        .candidate     (candidate_s),
        .seq_oob       (seq_oob_s),
        .ctl_bad       (ctl_bad_s)
    );

    // HALT and FAULT are absorbing; an illegal target leaves pc on the last legal address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
            count_r  <= 32'd0;
        end else if (halted_r || fault_r || stall) begin
            pc_r     <= pc_r;
            halted_r <= halted_r;
            fault_r  <= fault_r;
            count_r  <= count_r;
        end else if (seq_oob_s) begin
            halted_r <= 1'b1;
        end else if (ctl_bad_s) begin
            fault_r  <= 1'b1;
        end else begin
            pc_r     <= candidate_s;
            count_r  <= count_r + 32'd1;
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign instr_out   = instruction;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios from the
// test plan plus a randomized run against an arithmetic reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_offset, instruction;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4, instr_out, fetch_count;
    logic        halted, fault;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    longint m_pc, m_cnt;
    bit     m_halt, m_fault;

    localparam longint LIMIT = 64 * 4;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
        .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4),
        .instr_out(instr_out), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_offset = 32'd0; jump_index = 26'd0; instruction = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({pc, halted, fault, fetch_count} !== {32'h0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset: got pc=%h h=%b f=%b cnt=%0d, want pc=0 h=0 f=0 cnt=0",
                     pc, halted, fault, fetch_count);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = 32'(4 * (i + 1));
            n_cmp++;
            if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
                n_fail++;
                $display("FAIL seq_pc[%0d]: got pc=%h pc4=%h, want pc=%h pc4=%h",
                         i, pc, pc_plus4, exp_pc, exp_pc + 32'd4);
            end
        end
        n_cmp++;
        if ({fetch_count, halted, fault} !== {32'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_count: got cnt=%0d h=%b f=%b, want cnt=3 h=0 f=0",
                     fetch_count, halted, fault);
        end
    endtask

    task automatic test_branch();
        do_reset();
        run(6);
        branch_taken = 1'b1; branch_offset = 32'd8;
        tick();
        idle();
        n_cmp++;
        if (pc !== 32'h3C) begin
            n_fail++; $display("FAIL branch_fwd: got pc=%h, want 3c", pc);
        end
        do_reset();
        run(6);
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF9;
        tick();
        idle();
        n_cmp++;
        if (pc !== 32'h00 || fetch_count !== 32'd7) begin
            n_fail++;
            $display("FAIL branch_back: got pc=%h cnt=%0d, want pc=0 cnt=7", pc, fetch_count);
        end
    endtask

    task automatic test_jump_priority();
        do_reset();
        run(6);
        branch_taken = 1'b1; branch_offset = 32'd8;
        tick();
        jump = 1'b1; jump_index = 26'd3; branch_taken = 1'b1; branch_offset = 32'd1;
        tick();
        idle();
        n_cmp++;
        if (pc !== 32'h0C || fault !== 1'b0) begin
            n_fail++; $display("FAIL jump_priority: got pc=%h f=%b, want pc=0c f=0", pc, fault);
        end
    endtask

    task automatic test_stall();
        do_reset();
        run(4);
        stall = 1'b1; jump = 1'b1; jump_index = 26'd10;
        run(2);
        n_cmp++;
        if (pc !== 32'h10 || fetch_count !== 32'd4) begin
            n_fail++;
            $display("FAIL stall_hold: got pc=%h cnt=%0d, want pc=10 cnt=4", pc, fetch_count);
        end
        stall = 1'b0;
        tick();
        idle();
        n_cmp++;
        if (pc !== 32'h28 || fetch_count !== 32'd5) begin
            n_fail++;
            $display("FAIL stall_release: got pc=%h cnt=%0d, want pc=28 cnt=5", pc, fetch_count);
        end
    endtask

    task automatic test_fault();
        do_reset();
        run(2);
        branch_taken = 1'b1; branch_offset = 32'd100;
        tick();
        n_cmp++;
        if ({fault, halted, pc, fetch_count} !== {1'b1, 1'b0, 32'h08, 32'd2}) begin
            n_fail++;
            $display("FAIL fault_set: got f=%b h=%b pc=%h cnt=%0d, want f=1 h=0 pc=08 cnt=2",
                     fault, halted, pc, fetch_count);
        end
        idle();
        jump = 1'b1; jump_index = 26'd1;
        run(3);
        idle();
        run(2);
        n_cmp++;
        if ({fault, pc, fetch_count} !== {1'b1, 32'h08, 32'd2}) begin
            n_fail++;
            $display("FAIL fault_sticky: got f=%b pc=%h cnt=%0d, want f=1 pc=08 cnt=2",
                     fault, pc, fetch_count);
        end
    endtask

    task automatic test_halt_and_reset();
        do_reset();
        run(63);
        n_cmp++;
        if (pc !== 32'hFC || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_pre: got pc=%h h=%b, want pc=fc h=0", pc, halted);
        end
        tick();
        n_cmp++;
        if ({halted, fault, pc, fetch_count} !== {1'b1, 1'b0, 32'hFC, 32'd63}) begin
            n_fail++;
            $display("FAIL halt_set: got h=%b f=%b pc=%h cnt=%0d, want h=1 f=0 pc=fc cnt=63",
                     halted, fault, pc, fetch_count);
        end
        jump = 1'b1; jump_index = 26'd2;
        run(2);
        n_cmp++;
        if ({halted, pc, fetch_count} !== {1'b1, 32'hFC, 32'd63}) begin
            n_fail++;
            $display("FAIL halt_sticky: got h=%b pc=%h cnt=%0d, want h=1 pc=fc cnt=63",
                     halted, pc, fetch_count);
        end
        reset = 1'b1; stall = 1'b1;
        tick();
        idle();
        n_cmp++;
        if ({pc, halted, fault, fetch_count} !== {32'h0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_midrun: got pc=%h h=%b f=%b cnt=%0d, want all zero",
                     pc, halted, fault, fetch_count);
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            instruction = w;
            #1;
            n_cmp++;
            if (instr_out !== w) begin
                n_fail++; $display("FAIL instr_pass: got %h, want %h", instr_out, w);
            end
        end
        idle();
    endtask

    // Reference step: applies the fetch rules with plain integer arithmetic.
    task automatic model_step();
        longint tgt;
        bit     ctl;
        if (reset) begin
            m_pc = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
        end else if (m_halt || m_fault || stall) begin
            m_pc = m_pc;
        end else begin
            if (jump) begin
                tgt = (((m_pc + 4) / 268435456) % 16) * 268435456 + longint'(jump_index) * 4;
                ctl = 1;
            end else if (branch_taken) begin
                tgt = (m_pc + 4 + longint'($signed(branch_offset)) * 4) & 64'hFFFF_FFFF;
                ctl = 1;
            end else begin
                tgt = m_pc + 4;
                ctl = 0;
            end
            if (ctl && (tgt >= LIMIT || tgt % 4 != 0)) m_fault = 1;
            else if (!ctl && tgt >= LIMIT) m_halt = 1;
            else begin
                m_pc = tgt;
                m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
            end
        end
    endtask

    task automatic test_random();
        m_pc = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 39) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            branch_taken  = ($urandom_range(0, 6) == 0);
            branch_offset = ($urandom_range(0, 19) == 0) ? $urandom
                            : 32'($signed($urandom_range(0, 40)) - 20);
            jump_index    = 26'($urandom_range(0, 70));
            instruction   = $urandom;
            model_step();
            tick();
            n_cmp++;
            if (pc !== 32'(m_pc) || pc_plus4 !== 32'(m_pc + 4) || halted !== m_halt ||
                fault !== m_fault || fetch_count !== 32'(m_cnt) || instr_out !== instruction) begin
                n_fail++;
                $display("FAIL random[%0d]: got pc=%h h=%b f=%b cnt=%0d, want pc=%h h=%b f=%b cnt=%0d",
                         i, pc, halted, fault, fetch_count, 32'(m_pc), m_halt, m_fault, 32'(m_cnt));
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_stall();
        test_fault();
        test_halt_and_reset();
        test_passthrough();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
